// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package : sram_arb_pkg
// Brief   : Shared widths, types and FSM encoding for sram_1024x36_arb.
// Rev     : 1.0  initial release
// ============================================================================
package sram_arb_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 36;
  localparam int DEPTH  = 1024;

  typedef enum logic {INIT, RUN} arb_state_e;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

endpackage : sram_arb_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Brief  : Round-robin arbiter with a combinational one-hot grant. The search
//          starts at the pointer; the pointer moves to winner+1 when advance
//          is high and a grant was issued. Masked requests are ignored.
// Rev    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          gnt_any
);

  logic [IW-1:0] r_ptr;
  logic [N-1:0]  w_req;

  assign w_req = req & ~mask;

  // First unmasked request at or after the pointer, wrapping modulo N.
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!gnt_any && w_req[(int'(r_ptr) + i) % N]) begin
        gnt_any                      = 1'b1;
        gnt[(int'(r_ptr) + i) % N]   = 1'b1;
        gnt_id                       = IW'((int'(r_ptr) + i) % N);
      end
    end
  end

  // Pointer moves past the winner only when the grant turned into a transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (advance && gnt_any) begin
      r_ptr <= (gnt_id == IW'(N - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/sram_1024x36_arb.sv
`default_nettype none
// ============================================================================
// Module : sram_1024x36_arb
// Brief  : Shares a 1024x36 1W/1R SRAM between NREQ clients. Clears the array
//          after reset, then arbitrates each port round-robin. Idle write
//          cycles are steered to DUMMY_ADDR since the SRAM writes every clock.
//          Optional macro SRAM_ARB_WR_BYPASS_EN: colliding reads are granted
//          and served from a forward register; otherwise they are masked.
// Rev    : 1.0  initial release
// ============================================================================
module sram_1024x36_arb
  import sram_arb_pkg::*;
#(
  parameter int          NREQ       = 4,
  parameter int          IDW        = 2,
  parameter logic [9:0]  DUMMY_ADDR = 10'h3FF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       wr_valid,
  input  logic [NREQ*10-1:0]    wr_addr,
  input  logic [NREQ*36-1:0]    wr_data,
  output logic [NREQ-1:0]       wr_ready,
  input  logic [NREQ-1:0]       rd_valid,
  input  logic [NREQ*10-1:0]    rd_addr,
  output logic [NREQ-1:0]       rd_ready,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [35:0]           rsp_data,
  output logic                  init_done,
  output logic [9:0]            mem_waddr,
  output logic [35:0]           mem_wdata,
  output logic [9:0]            mem_raddr,
  input  logic [35:0]           mem_rdata
);

  arb_state_e    r_state, w_state_nxt;
  addr_t         r_cnt;
  addr_t         r_raddr_hold;
  logic          w_run;
  logic [IDW-1:0] w_wid, w_rid;
  logic          w_wany, w_rany;
  addr_t         w_wr_addr, w_rd_addr;
  data_t         w_wr_data;
  logic [NREQ-1:0] w_rd_mask;

  assign w_run     = (r_state == RUN);
  assign init_done = w_run;

  // State register for the clear sweep.
  always_ff @(posedge clk) begin
    if (rst) r_state <= INIT;
    else     r_state <= w_state_nxt;
  end

  // Leave INIT once the last address of the sweep has been written.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == INIT && r_cnt == addr_t'(DEPTH - 1)) w_state_nxt = RUN;
  end

  // Sweep address counter, active only while clearing.
  always_ff @(posedge clk) begin
    if (rst)                  r_cnt <= '0;
    else if (r_state == INIT) r_cnt <= r_cnt + 1'b1;
  end

  // Every write grant is a transfer because grants only go to valid clients.
  rr_arbiter #(.N(NREQ), .IW(IDW)) u_wr_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (wr_valid),
    .mask    ({NREQ{~w_run}}),
    .advance (1'b1),
    .gnt     (wr_ready),
    .gnt_id  (w_wid),
    .gnt_any (w_wany)
  );

  assign w_wr_addr = wr_addr[int'(w_wid)*ADDR_W +: ADDR_W];
  assign w_wr_data = wr_data[int'(w_wid)*DATA_W +: DATA_W];

  // Write port: sweep in INIT, granted client in RUN, sink address when idle.
  always_comb begin
    mem_waddr = DUMMY_ADDR;
    mem_wdata = '0;
    if (!w_run) begin
      mem_waddr = r_cnt;
    end else if (w_wany) begin
      mem_waddr = w_wr_addr;
      mem_wdata = w_wr_data;
    end
  end

`ifdef SRAM_ARB_WR_BYPASS_EN
  logic  r_fwd_sel;
  data_t r_fwd_data;

  assign w_rd_mask = {NREQ{~w_run}};
`else
  logic [NREQ-1:0] w_rd_coll;

  // A read aimed at this cycle's write address would see stale data; hide it.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_coll
    assign w_rd_coll[gi] = w_wany && (rd_addr[gi*ADDR_W +: ADDR_W] == w_wr_addr);
  end

  assign w_rd_mask = {NREQ{~w_run}} | w_rd_coll;
`endif

  rr_arbiter #(.N(NREQ), .IW(IDW)) u_rd_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (rd_valid),
    .mask    (w_rd_mask),
    .advance (1'b1),
    .gnt     (rd_ready),
    .gnt_id  (w_rid),
    .gnt_any (w_rany)
  );

  assign w_rd_addr = rd_addr[int'(w_rid)*ADDR_W +: ADDR_W];
  assign mem_raddr = w_rany ? w_rd_addr : r_raddr_hold;

  // Response pipeline: SRAM data arrives one clock after the address.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      r_raddr_hold <= '0;
    end else begin
      rsp_valid    <= w_rany;
      r_raddr_hold <= mem_raddr;
      if (w_rany) rsp_id <= w_rid;
    end
  end

`ifdef SRAM_ARB_WR_BYPASS_EN
  // Capture the write data when the granted read hits the written address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fwd_sel  <= 1'b0;
      r_fwd_data <= '0;
    end else begin
      r_fwd_sel  <= w_rany && w_wany && (w_rd_addr == w_wr_addr);
      r_fwd_data <= w_wr_data;
    end
  end

  assign rsp_data = !rsp_valid ? '0 : (r_fwd_sel ? r_fwd_data : mem_rdata);
`else
  assign rsp_data = rsp_valid ? mem_rdata : '0;
`endif

endmodule : sram_1024x36_arb
`default_nettype wire

// File: tb/tb_sram_1024x36_arb.sv
`default_nettype none
// ============================================================================
// Module : tb_sram_1024x36_arb
// Brief  : Self-checking bench for sram_1024x36_arb with a behavioural
//          read-old-data SRAM, a response scoreboard and directed vectors.
// Rev    : 1.0  initial release
// ============================================================================
module tb_sram_1024x36_arb;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   wr_valid, rd_valid, wr_ready, rd_ready;
  logic [39:0]  wr_addr, rd_addr;
  logic [143:0] wr_data;
  logic         rsp_valid, init_done;
  logic [1:0]   rsp_id;
  logic [35:0]  rsp_data, mem_wdata, mem_rdata;
  logic [9:0]   mem_waddr, mem_raddr;

  int errors = 0;
  int checks = 0;

  sram_1024x36_arb #(.NREQ(4), .IDW(2), .DUMMY_ADDR(10'h3FF)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .init_done(init_done),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: writes every clock, registered read returns old data.
  logic [35:0] sram [1024];
  initial for (int i = 0; i < 1024; i++) sram[i] = 36'hDEAD0BEEF;
  always @(posedge clk) begin
    sram[mem_waddr] <= mem_wdata;
    mem_rdata       <= sram[mem_raddr];
  end

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct { logic [1:0] id; logic [35:0] data; } rsp_t;
  rsp_t        q[$];
  rsp_t        e;
  logic [35:0] ref_mem [1024];
  logic        wx;
  logic [9:0]  wa, ra;
  logic [35:0] wd;
  initial for (int i = 0; i < 1024; i++) ref_mem[i] = '0;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      if (rsp_valid) begin
        if (q.size() == 0) chk("sb_rsp_unexpected", 64'(rsp_valid), 64'd0);
        else begin
          e = q.pop_front();
          chk("sb_rsp_id", 64'(rsp_id), 64'(e.id));
          chk("sb_rsp_data", 64'(rsp_data), 64'(e.data));
        end
      end else if (q.size() != 0) begin
        chk("sb_rsp_missing", 64'(rsp_valid), 64'd1);
        void'(q.pop_front());
      end
      if (init_done) begin
        chk("grant_onehot", 64'($countones(wr_ready) <= 1 && $countones(rd_ready) <= 1 &&
            (wr_ready & ~wr_valid) == 4'd0 && (rd_ready & ~rd_valid) == 4'd0), 64'd1);
        wx = 1'b0; wa = '0; wd = '0;
        for (int i = 0; i < 4; i++)
          if (wr_valid[i] && wr_ready[i]) begin
            wx = 1'b1; wa = wr_addr[i*10 +: 10]; wd = wr_data[i*36 +: 36];
          end
        if (wx) chk("mem_write", 64'({mem_waddr, mem_wdata}), 64'({wa, wd}));
        else    chk("mem_write_idle", 64'({mem_waddr, mem_wdata}), 64'({10'h3FF, 36'd0}));
        for (int i = 0; i < 4; i++)
          if (rd_valid[i] && rd_ready[i]) begin
            ra = rd_addr[i*10 +: 10];
            chk("mem_raddr", 64'(mem_raddr), 64'(ra));
            e.id   = 2'(i);
            e.data = (wx && wa == ra) ? wd : ref_mem[ra];
            q.push_back(e);
          end
        if (wx) ref_mem[wa] = wd;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic set_client(int i, logic [9:0] w_a, logic [35:0] w_d, logic [9:0] r_a);
    wr_addr[i*10 +: 10] = w_a;
    wr_data[i*36 +: 36] = w_d;
    rd_addr[i*10 +: 10] = r_a;
  endtask

  typedef struct {
    logic [3:0]  wv, rv, exp_wr, exp_rd;
    logic        exp_rv;
    logic [1:0]  exp_id;
    logic [35:0] exp_data;
  } vec_t;
  vec_t tbl[11];

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int sweep_bad, max_w, max_r, wait_w, wait_r;
    tbl[0]  = '{4'hF, 4'h0, 4'h1, 4'h0, 1'b0, 2'd0, 36'h0};
    tbl[1]  = '{4'hF, 4'h0, 4'h2, 4'h0, 1'b0, 2'd0, 36'h0};
    tbl[2]  = '{4'hF, 4'h0, 4'h4, 4'h0, 1'b0, 2'd0, 36'h0};
    tbl[3]  = '{4'hF, 4'h0, 4'h8, 4'h0, 1'b0, 2'd0, 36'h0};
    tbl[4]  = '{4'hF, 4'h0, 4'h1, 4'h0, 1'b0, 2'd0, 36'h0};
    tbl[5]  = '{4'h0, 4'hF, 4'h0, 4'h1, 1'b0, 2'd0, 36'h0};
    tbl[6]  = '{4'h0, 4'hE, 4'h0, 4'h2, 1'b1, 2'd0, 36'hA0};
    tbl[7]  = '{4'h0, 4'hC, 4'h0, 4'h4, 1'b1, 2'd1, 36'hA1};
    tbl[8]  = '{4'h0, 4'h8, 4'h0, 4'h8, 1'b1, 2'd2, 36'hA2};
    tbl[9]  = '{4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 2'd3, 36'hA3};
    tbl[10] = '{4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0, 36'h0};

    rst = 1'b1; wr_valid = '0; rd_valid = '0; wr_addr = '0; rd_addr = '0; wr_data = '0;

    // 1: reset state, full sweep, idle sink address
    repeat (3) tick();
    chk("reset_ready", 64'({wr_ready, rd_ready}), 64'd0);
    chk("reset_rsp", 64'({rsp_valid, rsp_id, rsp_data}), 64'd0);
    chk("reset_init_done", 64'(init_done), 64'd0);
    chk("reset_mem", 64'({mem_waddr, mem_wdata, mem_raddr}), 64'd0);
    rst = 1'b0; #1;
    sweep_bad = 0;
    for (int k = 0; k < 1024; k++) begin
      if (mem_waddr != 10'(k) || mem_wdata != '0 || init_done) sweep_bad++;
      tick();
    end
    chk("sweep1_bad_cycles", 64'(sweep_bad), 64'd0);
    chk("init_done_1024", 64'(init_done), 64'd1);
    chk("idle_sink", 64'({mem_waddr, mem_wdata}), 64'({10'h3FF, 36'd0}));

    // 2: reset mid-sweep restarts at 0; no grants while clearing
    rst = 1'b1; tick(); rst = 1'b0; #1;
    repeat (500) tick();
    chk("sweep_at_500", 64'(mem_waddr), 64'd500);
    rst = 1'b1; tick();
    chk("sweep_restart", 64'(mem_waddr), 64'd0);
    rst = 1'b0; wr_valid = 4'hF; rd_valid = 4'hF; #1;
    sweep_bad = 0;
    for (int k = 0; k < 1024; k++) begin
      if (mem_waddr != 10'(k) || mem_wdata != '0 || init_done || wr_ready != '0 || rd_ready != '0)
        sweep_bad++;
      tick();
    end
    wr_valid = '0; rd_valid = '0; #1;
    chk("sweep2_bad_cycles", 64'(sweep_bad), 64'd0);
    chk("init_done_after_restart", 64'(init_done), 64'd1);

    // 3/4: table - write rotation then back-to-back reads of 0..3
    for (int i = 0; i < 4; i++) set_client(i, 10'(i), 36'hA0 + 36'(i), 10'(i));
    for (int v = 0; v < 11; v++) begin
      wr_valid = tbl[v].wv; rd_valid = tbl[v].rv; #1;
      chk($sformatf("tbl%0d_wr_ready", v), 64'(wr_ready), 64'(tbl[v].exp_wr));
      chk($sformatf("tbl%0d_rd_ready", v), 64'(rd_ready), 64'(tbl[v].exp_rd));
      chk($sformatf("tbl%0d_rsp_valid", v), 64'(rsp_valid), 64'(tbl[v].exp_rv));
      if (tbl[v].exp_rv)
        chk($sformatf("tbl%0d_rsp", v), 64'({rsp_id, rsp_data}), 64'({tbl[v].exp_id, tbl[v].exp_data}));
      tick();
    end

    // 4: client 2 reads addr 5, response one cycle later
    set_client(0, 10'd5, 36'h5555, 10'd0);
    wr_valid = 4'h1; #1;
    chk("wr5_grant", 64'(wr_ready), 64'h1);
    tick();
    wr_valid = '0; set_client(2, 10'd2, 36'hA2, 10'd5); rd_valid = 4'h4; #1;
    chk("rd5_grant", 64'({rd_ready, mem_raddr}), 64'({4'h4, 10'd5}));
    tick();
    rd_valid = '0; #1;
    chk("rd5_rsp", 64'({rsp_valid, rsp_id, rsp_data}), 64'({1'b1, 2'd2, 36'h5555}));

    // 5: write and read of addr 7 in the same cycle
    set_client(0, 10'd7, 36'h123456789, 10'd0);
    set_client(1, 10'd1, 36'hA1, 10'd7);
    wr_valid = 4'h1; rd_valid = 4'h2; #1;
    chk("coll_wr_grant", 64'(wr_ready), 64'h1);
`ifdef SRAM_ARB_WR_BYPASS_EN
    chk("coll_rd_grant", 64'(rd_ready), 64'h2);
    tick();
    wr_valid = '0; rd_valid = '0; #1;
`else
    chk("coll_rd_masked", 64'(rd_ready), 64'h0);
    tick();
    wr_valid = '0; #1;
    chk("coll_rd_deferred", 64'({rd_ready, rsp_valid}), 64'({4'h2, 1'b0}));
    tick();
    rd_valid = '0; #1;
`endif
    chk("coll_rsp", 64'({rsp_valid, rsp_id, rsp_data}), 64'({1'b1, 2'd1, 36'h123456789}));

    // 6: client 1 always requesting under random contention
    for (int i = 0; i < 4; i++) set_client(i, 10'd200 + 10'(i), 36'h0, 10'd100 + 10'(i));
    max_w = 0; max_r = 0; wait_w = 0; wait_r = 0;
    for (int c = 0; c < 200; c++) begin
      wr_valid = 4'($urandom) | 4'h2;
      rd_valid = 4'($urandom) | 4'h2;
      for (int i = 0; i < 4; i++) wr_data[i*36 +: 36] = {4'($urandom), 32'($urandom)};
      #1;
      wait_w = wr_ready[1] ? 0 : wait_w + 1;
      wait_r = rd_ready[1] ? 0 : wait_r + 1;
      if (wait_w > max_w) max_w = wait_w;
      if (wait_r > max_r) max_r = wait_r;
      tick();
    end
    chk("fair_wr_max_wait", 64'(max_w <= 3), 64'd1);
    chk("fair_rd_max_wait", 64'(max_r <= 3), 64'd1);

    wr_valid = '0; rd_valid = '0;
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_sram_1024x36_arb
`default_nettype wire
